wrap_accumulator: RTL and testbench
===================================

// Module: wrap_accumulator
// PURPOSE
//   Downstream stage of the 4-bit counter.
//   - Consumes the counter's overflow strobe and its live 4-bit count.
//   - Counts counter wraps into a wider WIDTH-bit accumulator.
//   - Provides a valid/ready snapshot port that returns {acc, cnt_in} atomically
//     to a slower reader.
// PARAMETERS
//   WIDTH  8  accumulator width (wrap count), >= 2
//   CNT_W  4  width of upstream count input cnt_in
// PORTS
//   clk         in   1              rising-edge clock, single clock domain
//   rst_n       in   1              asynchronous active-low reset
//   en          in   1              count enable, level
//   clr         in   1              synchronous clear of acc_out / acc_flag
//   ovf_in      in   1              upstream overflow, level; one wrap per rising edge
//   cnt_in      in   CNT_W          upstream live count
//   snap_req    in   1              snapshot request, single-cycle pulse
//   snap_ready  in   1              reader accepts snapshot
//   snap_valid  out  1              snapshot held, valid
//   snap_data   out  WIDTH+CNT_W    {acc_out, cnt_in} captured at request
//   acc_out     out  WIDTH          current wrap count
//   acc_flag    out  1              sticky wrap/saturation flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     - acc_out=0, acc_flag=0, snap_valid=0, snap_data=0, ovf_q=0, state=IDLE.
//     - Takes effect immediately, mid-snapshot included; pending snapshot is lost.
//   Edge detect
//     - ovf_q <= ovf_in every cycle, regardless of en.
//     - inc = en & ovf_in & ~ovf_q.
//     - ovf_in held high for N cycles counts once.
//     - Enabling while ovf_in is already high does not count.
//   Accumulate
//     - inc=1 -> acc_out <= acc_out+1 next cycle (latency 1).
//     - Counting continues in every state while en=1.
//   Clear
//     - clr=1 -> acc_out <= 0 and acc_flag <= 0 next cycle.
//     - Wins over a same-cycle inc.
//     - Does not affect snap_valid or snap_data.
//   FSM states: IDLE (en=0, no snapshot), RUN (en=1, no snapshot), HOLD (snapshot pending).
//     - IDLE <-> RUN follows en.
//     - IDLE/RUN + snap_req -> HOLD next cycle:
//       snap_data <= {acc_out, cnt_in} sampled in the request cycle (pre-increment); snap_valid <= 1.
//     - HOLD:
//       snap_data stable; snap_req ignored.
//       snap_valid & snap_ready -> snap_valid <= 0, next state RUN if en else IDLE.
//     - snap_req in the same cycle as the accepting handshake is dropped; the reader re-issues it.
//   Width: acc_out is WIDTH bits unsigned; snap_data MSBs = acc_out, LSBs = cnt_in.
// CONFIGURATION
//   Macro WRAP_ACC_SATURATE_EN
//     - Undefined: acc_out wraps 2^WIDTH-1 -> 0; the inc that wraps sets acc_flag (sticky).
//     - Defined:   acc_out saturates at 2^WIDTH-1; further incs leave it unchanged and set acc_flag (sticky).
//     - Both modes: acc_flag is cleared only by clr or reset.
// TESTING
//   T1 reset: acc_out=5, snap_valid=1; drop rst_n mid-cycle -> all outputs 0 before next clk edge.
//   T2 edges: en=1, three 1-cycle ovf_in pulses, then ovf_in high 4 cycles -> acc_out=4.
//      en=0 plus 2 pulses -> acc_out stays 4.
//   T3 snapshot: acc_out=3, cnt_in=4'hA, snap_req -> next cycle snap_valid=1, snap_data=12'h03A.
//      snap_ready=0 for 5 cycles with 2 incs -> snap_data still 12'h03A, acc_out=5.
//      snap_ready=1 -> snap_valid=0 next cycle.
//   T4 clr vs inc: acc_out=7, clr=1 with an ovf_in edge in the same cycle -> acc_out=0, acc_flag=0.
//   T5 overflow: WIDTH=8, 256 edges from 0.
//      Without macro -> acc_out=0, acc_flag=1.
//      With WRAP_ACC_SATURATE_EN -> acc_out=8'hFF, acc_flag=1.
//   T6 request collision: snap_req in the accept cycle -> snap_valid=0 next cycle, no new snapshot.

Source files
------------

// File: rtl/wrap_accumulator.sv
// Counts rising edges of the upstream overflow into a WIDTH-bit accumulator and serves {acc, cnt} snapshots over valid/ready.
// Accumulate latency 1 cycle; a snapshot is held stable until accepted. Saturating mode is enabled by WRAP_ACC_SATURATE_EN.
module wrap_accumulator #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clr,
  input  logic                   ovf_in,
  input  logic [CNT_W-1:0]       cnt_in,
  input  logic                   snap_req,
  input  logic                   snap_ready,
  output logic                   snap_valid,
  output logic [WIDTH+CNT_W-1:0] snap_data,
  output logic [WIDTH-1:0]       acc_out,
  output logic                   acc_flag
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic                   ovf_q;
  logic [WIDTH-1:0]       acc_q, acc_d;
  logic                   flag_q, flag_d;
  logic                   snap_valid_q, snap_valid_d;
  logic [WIDTH+CNT_W-1:0] snap_data_q, snap_data_d;
  logic                   inc;
  logic                   acc_max;

  // Only the rising edge counts, so a long overflow level is one wrap.
  assign inc     = en & ovf_in & ~ovf_q;
  assign acc_max = (acc_q == {WIDTH{1'b1}});

  always_comb begin
    acc_d  = acc_q;
    flag_d = flag_q;
    if (clr) begin
      acc_d  = '0;
      flag_d = 1'b0;
    end else if (inc) begin
`ifdef WRAP_ACC_SATURATE_EN
      if (acc_max) begin
        flag_d = 1'b1;
      end else begin
        acc_d = acc_q + WIDTH'(1);
      end
`else
      acc_d = acc_q + WIDTH'(1);
      if (acc_max) begin
        flag_d = 1'b1;
      end
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    snap_valid_d = snap_valid_q;
    snap_data_d  = snap_data_q;
    case (state_q)
      IDLE, RUN: begin
        if (snap_req) begin
          state_d      = HOLD;
          snap_valid_d = 1'b1;
          snap_data_d  = {acc_q, cnt_in};
        end else begin
          state_d = en ? RUN : IDLE;
        end
      end
      HOLD: begin
        // A request coincident with the accept is dropped; the reader re-issues it.
        if (snap_valid_q && snap_ready) begin
          snap_valid_d = 1'b0;
          state_d      = en ? RUN : IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        snap_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ovf_q        <= 1'b0;
      acc_q        <= '0;
      flag_q       <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      ovf_q        <= ovf_in;
      acc_q        <= acc_d;
      flag_q       <= flag_d;
      snap_valid_q <= snap_valid_d;
      snap_data_q  <= snap_data_d;
    end
  end

  assign acc_out    = acc_q;
  assign acc_flag   = flag_q;
  assign snap_valid = snap_valid_q;
  assign snap_data  = snap_data_q;

endmodule

// File: tb/tb_wrap_accumulator.sv
// Directed bench for wrap_accumulator; snapshot payloads are checked through a scoreboard queue.
module tb_wrap_accumulator;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic                   clk;
  logic                   rst_n;
  logic                   en;
  logic                   clr;
  logic                   ovf_in;
  logic [CNT_W-1:0]       cnt_in;
  logic                   snap_req;
  logic                   snap_ready;
  logic                   snap_valid;
  logic [WIDTH+CNT_W-1:0] snap_data;
  logic [WIDTH-1:0]       acc_out;
  logic                   acc_flag;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+CNT_W-1:0] sb[$];

  wrap_accumulator #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .clr        (clr),
    .ovf_in     (ovf_in),
    .cnt_in     (cnt_in),
    .snap_req   (snap_req),
    .snap_ready (snap_ready),
    .snap_valid (snap_valid),
    .snap_data  (snap_data),
    .acc_out    (acc_out),
    .acc_flag   (acc_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    for (int i = 0; i < n; i++) begin
      ovf_in = 1'b1;
      tick();
      ovf_in = 1'b0;
      tick();
    end
  endtask

  // Snapshot consumer: every accepted beat must match the oldest queued request.
  always @(negedge clk) begin
    if (rst_n && snap_valid && snap_ready) begin
      check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) check("snap_sb", 32'(snap_data), 32'(sb.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; ovf_in = 1'b0;
    cnt_in = '0; snap_req = 1'b0; snap_ready = 1'b0;
    #12;
    check("rst_acc", 32'(acc_out), 32'd0);
    check("rst_flag", 32'(acc_flag), 32'd0);
    check("rst_valid", 32'(snap_valid), 32'd0);
    check("rst_data", 32'(snap_data), 32'd0);
    tick();
    rst_n = 1'b1;
    en = 1'b1;
    tick();

    // Edge detection
    pulse(3);
    ovf_in = 1'b1;
    repeat (4) tick();
    ovf_in = 1'b0;
    tick();
    check("t2_acc4", 32'(acc_out), 32'd4);
    en = 1'b0;
    pulse(2);
    check("t2_en_off", 32'(acc_out), 32'd4);
    ovf_in = 1'b1;
    tick();
    en = 1'b1;
    repeat (2) tick();
    ovf_in = 1'b0;
    tick();
    check("t2_en_while_high", 32'(acc_out), 32'd4);

    // Snapshot held under backpressure
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pulse(3);
    check("t3_acc3", 32'(acc_out), 32'd3);
    cnt_in = 4'hA;
    snap_req = 1'b1;
    sb.push_back({8'd3, 4'hA});
    tick();
    snap_req = 1'b0;
    cnt_in = 4'h5;
    check("t3_valid", 32'(snap_valid), 32'd1);
    check("t3_data", 32'(snap_data), 32'h03A);
    pulse(2);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    check("t3_data_held", 32'(snap_data), 32'h03A);
    check("t3_valid_held", 32'(snap_valid), 32'd1);
    check("t3_acc5", 32'(acc_out), 32'd5);
    snap_ready = 1'b1;
    tick();
    snap_ready = 1'b0;
    check("t3_released", 32'(snap_valid), 32'd0);

    // Overflow boundary
    clr = 1'b1;
    tick();
    clr = 1'b0;
    pulse(255);
    check("t5_acc_max", 32'(acc_out), 32'hFF);
    check("t5_flag_pre", 32'(acc_flag), 32'd0);
    pulse(1);
`ifdef WRAP_ACC_SATURATE_EN
    check("t5_acc", 32'(acc_out), 32'hFF);
`else
    check("t5_acc", 32'(acc_out), 32'd0);
`endif
    check("t5_flag", 32'(acc_flag), 32'd1);
    pulse(7);
`ifdef WRAP_ACC_SATURATE_EN
    check("t5_acc_after", 32'(acc_out), 32'hFF);
`else
    check("t5_acc_after", 32'(acc_out), 32'd7);
`endif
    check("t5_flag_sticky", 32'(acc_flag), 32'd1);

    // Clear wins over a same-cycle increment
    clr = 1'b1;
    ovf_in = 1'b1;
    tick();
    clr = 1'b0;
    ovf_in = 1'b0;
    check("t4_acc", 32'(acc_out), 32'd0);
    check("t4_flag", 32'(acc_flag), 32'd0);
    tick();
    check("t4_no_late_inc", 32'(acc_out), 32'd0);

    // Request colliding with accept is dropped
    cnt_in = 4'h3;
    snap_req = 1'b1;
    sb.push_back({8'd0, 4'h3});
    tick();
    check("t6_valid", 32'(snap_valid), 32'd1);
    snap_ready = 1'b1;
    tick();
    snap_req = 1'b0;
    snap_ready = 1'b0;
    check("t6_dropped", 32'(snap_valid), 32'd0);
    tick();
    check("t6_still_idle", 32'(snap_valid), 32'd0);

    // Asynchronous reset mid-snapshot
    pulse(5);
    cnt_in = 4'h9;
    snap_req = 1'b1;
    sb.push_back({8'd5, 4'h9});
    tick();
    snap_req = 1'b0;
    check("t1_pre_valid", 32'(snap_valid), 32'd1);
    check("t1_pre_acc", 32'(acc_out), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t1_acc", 32'(acc_out), 32'd0);
    check("t1_valid", 32'(snap_valid), 32'd0);
    check("t1_data", 32'(snap_data), 32'd0);
    check("t1_flag", 32'(acc_flag), 32'd0);
    sb.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
